// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared constants, encodings and types for the multicycle
//               CPU control unit (opcodes, functs, ALU codes, mux selects,
//               FSM state enum, latched instruction info).
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  // Opcode field (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  // Funct field (IR[5:0]) for R-type
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  // ALU operation codes
  localparam logic [2:0] ALU_LOAD_A = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_SUB    = 3'b010;
  localparam logic [2:0] ALU_AND    = 3'b011;
  localparam logic [2:0] ALU_CMP    = 3'b111;

  // Single-bit mux selects
  localparam logic IORD_PC       = 1'b0;
  localparam logic IORD_ALUOUT   = 1'b1;
  localparam logic WMS_REG_B     = 1'b0;
  localparam logic REGDST_RT     = 1'b0;
  localparam logic REGDST_RD     = 1'b1;
  localparam logic M2R_ALUOUT    = 1'b0;
  localparam logic M2R_MDR       = 1'b1;
  localparam logic SRCA_PC       = 1'b0;
  localparam logic SRCA_REG_A    = 1'b1;

  // Two-bit mux selects
  localparam logic [1:0] SRCB_REG_B   = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_TRAP   = 2'd3;

  typedef enum logic [3:0] {
    S_RST        = 4'd0,
    S_FETCH      = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_EXEC_R     = 4'd4,
    S_EXEC_I     = 4'd5,
    S_WB_ALU     = 4'd6,
    S_ADDR       = 4'd7,
    S_MEM_RD     = 4'd8,
    S_MEM_WAIT   = 4'd9,
    S_WB_MEM     = 4'd10,
    S_MEM_WR     = 4'd11,
    S_BRANCH     = 4'd12,
    S_JUMP       = 4'd13,
    S_TRAP       = 4'd14
  } state_t;

  // Per-instruction facts captured at DECODE so later states need not
  // re-inspect the IR fields.
  typedef struct packed {
    logic [2:0] alu_op;    // EXEC ALU operation
    logic       chk_ovf;   // overflow traps this instruction
    logic       is_rtype;  // write-back destination is rd
    logic       is_beq;    // branch on equal (else branch on not-equal)
    logic       is_lw;     // memory access is a load
  } instr_info_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Combinational instruction decoder. Maps opcode/funct to the
//               state that follows DECODE and to the EXEC-stage facts.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output state_t      next_state,
  output instr_info_t info
);

  // Unknown opcodes and unknown R-type functs fall through to TRAP
  always_comb begin
    next_state   = S_TRAP;
    info         = '0;
    info.alu_op  = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        info.is_rtype = 1'b1;
        case (funct)
          FN_ADD: begin
            next_state   = S_EXEC_R;
            info.alu_op  = ALU_ADD;
            info.chk_ovf = 1'b1;
          end
          FN_SUB: begin
            next_state   = S_EXEC_R;
            info.alu_op  = ALU_SUB;
            info.chk_ovf = 1'b1;
          end
          FN_AND: begin
            next_state   = S_EXEC_R;
            info.alu_op  = ALU_AND;
          end
          default: next_state = S_TRAP;
        endcase
      end
      OP_ADDI: begin
        next_state   = S_EXEC_I;
        info.chk_ovf = 1'b1;
      end
      OP_LW: begin
        next_state  = S_ADDR;
        info.is_lw  = 1'b1;
      end
      OP_SW:   next_state = S_ADDR;
      OP_BEQ: begin
        next_state  = S_BRANCH;
        info.is_beq = 1'b1;
      end
      OP_BNE:  next_state = S_BRANCH;
      OP_J:    next_state = S_JUMP;
      default: next_state = S_TRAP;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Multicycle control FSM for the CPU datapath. Moore-decoded
//               write enables, mux selects and ALU op codes; PC_W in BRANCH
//               is the only flag-gated output.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_00FC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       flag_overflow,
  input  logic       flag_igual,
  output logic       PC_W,
  output logic       Mem_W,
  output logic       MDR_W,
  output logic       RAA_W,
  output logic       IR_W,
  output logic       RB_W,
  output logic       Reg_AB_W,
  output logic       ALU_Out_Reg_W,
  output logic [2:0] ALUControl,
  output logic       IorD,
  output logic       WriteMemSrc,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource
);

  state_t      state;
  state_t      state_next;
  state_t      dec_next;
  instr_info_t dec_info;
  instr_info_t info_q;

  // The trap target itself is applied by the datapath's PCSource=3 input;
  // the parameter lives here so both blocks are configured from one place.
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;

  ctrl_decode u_decode (
    .opcode     (opcode),
    .funct      (funct),
    .next_state (dec_next),
    .info       (dec_info)
  );

  // State register; instruction facts are captured while leaving DECODE
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_RST;
      info_q <= '0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) info_q <= dec_info;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next    = S_FETCH;
    PC_W          = 1'b0;
    Mem_W         = 1'b0;
    MDR_W         = 1'b0;
    RAA_W         = 1'b0;
    IR_W          = 1'b0;
    RB_W          = 1'b0;
    Reg_AB_W      = 1'b0;
    ALU_Out_Reg_W = 1'b0;
    ALUControl    = ALU_LOAD_A;
    IorD          = IORD_PC;
    WriteMemSrc   = WMS_REG_B;
    RegDst        = REGDST_RT;
    MemToReg      = M2R_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_REG_B;
    PCSource      = PCSRC_ALU;
    case (state)
      S_RST:   state_next = S_FETCH;
      S_FETCH: begin
        IorD       = IORD_PC;
        state_next = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        IR_W       = 1'b1;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_FOUR;
        ALUControl = ALU_ADD;
        PCSource   = PCSRC_ALU;
        PC_W       = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        Reg_AB_W      = 1'b1;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_IMM_SH2;
        ALUControl    = ALU_ADD;
        ALU_Out_Reg_W = 1'b1;
        state_next    = dec_next;
      end
      S_EXEC_R, S_EXEC_I: begin
        ALUSrcA       = SRCA_REG_A;
        ALUSrcB       = (state == S_EXEC_R) ? SRCB_REG_B : SRCB_IMM;
        ALUControl    = info_q.alu_op;
        ALU_Out_Reg_W = 1'b1;
        state_next    = (info_q.chk_ovf && flag_overflow) ? S_TRAP : S_WB_ALU;
      end
      S_WB_ALU: begin
        RB_W     = 1'b1;
        MemToReg = M2R_ALUOUT;
        RegDst   = info_q.is_rtype ? REGDST_RD : REGDST_RT;
      end
      S_ADDR: begin
        ALUSrcA       = SRCA_REG_A;
        ALUSrcB       = SRCB_IMM;
        ALUControl    = ALU_ADD;
        ALU_Out_Reg_W = 1'b1;
        state_next    = info_q.is_lw ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        IorD       = IORD_ALUOUT;
        state_next = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        MDR_W      = 1'b1;
        state_next = S_WB_MEM;
      end
      S_WB_MEM: begin
        RB_W     = 1'b1;
        MemToReg = M2R_MDR;
        RegDst   = REGDST_RT;
      end
      S_MEM_WR: begin
        IorD        = IORD_ALUOUT;
        Mem_W       = 1'b1;
        WriteMemSrc = WMS_REG_B;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_REG_A;
        ALUSrcB    = SRCB_REG_B;
        ALUControl = ALU_CMP;
        PCSource   = PCSRC_ALUOUT;
        PC_W       = info_q.is_beq ? flag_igual : !flag_igual;
      end
      S_JUMP: begin
        PCSource = PCSRC_JUMP;
        PC_W     = 1'b1;
      end
      S_TRAP: begin
        PCSource = PCSRC_TRAP;
        PC_W     = 1'b1;
      end
      default: state_next = S_RST;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Scoreboard bench for control_unit. The driver pushes the
//               hand-computed output vector expected for each cycle; a
//               monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       flag_overflow;
  logic       flag_igual;
  logic       PC_W, Mem_W, MDR_W, RAA_W, IR_W, RB_W, Reg_AB_W, ALU_Out_Reg_W;
  logic [2:0] ALUControl;
  logic       IorD, WriteMemSrc, RegDst, MemToReg, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit #(.TRAP_VECTOR(32'h0000_00FC)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .flag_overflow (flag_overflow),
    .flag_igual    (flag_igual),
    .PC_W          (PC_W),
    .Mem_W         (Mem_W),
    .MDR_W         (MDR_W),
    .RAA_W         (RAA_W),
    .IR_W          (IR_W),
    .RB_W          (RB_W),
    .Reg_AB_W      (Reg_AB_W),
    .ALU_Out_Reg_W (ALU_Out_Reg_W),
    .ALUControl    (ALUControl),
    .IorD          (IorD),
    .WriteMemSrc   (WriteMemSrc),
    .RegDst        (RegDst),
    .MemToReg      (MemToReg),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .PCSource      (PCSource)
  );

  always #5 clk = ~clk;

  // Packed view of every output, RAA_W and WriteMemSrc included (always 0)
  logic [19:0] act;
  assign act = {PC_W, Mem_W, MDR_W, RAA_W, IR_W, RB_W, Reg_AB_W, ALU_Out_Reg_W,
                ALUControl, IorD, WriteMemSrc, RegDst, MemToReg, ALUSrcA,
                ALUSrcB, PCSource};

  function automatic logic [19:0] ev(
    input logic pcw, memw, mdrw, irw, rbw, abw, aow,
    input logic [2:0] aluc,
    input logic iord, regdst, m2r, srca,
    input logic [1:0] srcb, pcsrc);
    return {pcw, memw, mdrw, 1'b0, irw, rbw, abw, aow,
            aluc, iord, 1'b0, regdst, m2r, srca, srcb, pcsrc};
  endfunction

  //                                pcw mw md ir rb ab ao alu     io rd mr sa sb    pcs
  localparam logic [19:0] E_ZERO  = 20'h0;
  localparam logic [19:0] E_FETCH = 20'h0;
  localparam logic [19:0] E_FW    = ev(1, 0, 0, 1, 0, 0, 0, 3'b001, 0, 0, 0, 0, 2'd1, 2'd0);
  localparam logic [19:0] E_DEC   = ev(0, 0, 0, 0, 0, 1, 1, 3'b001, 0, 0, 0, 0, 2'd3, 2'd0);
  localparam logic [19:0] E_XADD  = ev(0, 0, 0, 0, 0, 0, 1, 3'b001, 0, 0, 0, 1, 2'd0, 2'd0);
  localparam logic [19:0] E_XSUB  = ev(0, 0, 0, 0, 0, 0, 1, 3'b010, 0, 0, 0, 1, 2'd0, 2'd0);
  localparam logic [19:0] E_XAND  = ev(0, 0, 0, 0, 0, 0, 1, 3'b011, 0, 0, 0, 1, 2'd0, 2'd0);
  localparam logic [19:0] E_XI    = ev(0, 0, 0, 0, 0, 0, 1, 3'b001, 0, 0, 0, 1, 2'd2, 2'd0);
  localparam logic [19:0] E_ADDR  = ev(0, 0, 0, 0, 0, 0, 1, 3'b001, 0, 0, 0, 1, 2'd2, 2'd0);
  localparam logic [19:0] E_WBR   = ev(0, 0, 0, 0, 1, 0, 0, 3'b000, 0, 1, 0, 0, 2'd0, 2'd0);
  localparam logic [19:0] E_WBI   = ev(0, 0, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 2'd0, 2'd0);
  localparam logic [19:0] E_MRD   = ev(0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 2'd0, 2'd0);
  localparam logic [19:0] E_MWAIT = ev(0, 0, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'd0, 2'd0);
  localparam logic [19:0] E_WBM   = ev(0, 0, 0, 0, 1, 0, 0, 3'b000, 0, 0, 1, 0, 2'd0, 2'd0);
  localparam logic [19:0] E_MWR   = ev(0, 1, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 2'd0, 2'd0);
  localparam logic [19:0] E_BR_T  = ev(1, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 1, 2'd0, 2'd1);
  localparam logic [19:0] E_BR_N  = ev(0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0, 0, 1, 2'd0, 2'd1);
  localparam logic [19:0] E_JUMP  = ev(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'd0, 2'd2);
  localparam logic [19:0] E_TRAP  = ev(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'd0, 2'd3);

  typedef struct {
    string       name;
    logic [19:0] exp;
  } sb_item_t;

  sb_item_t sbq[$];

  // One cycle: wait for the edge, drive flags, record the expected outputs
  task automatic cyc(input string nm, input logic [19:0] e,
                     input logic ovf = 1'b0, input logic eq = 1'b0);
    sb_item_t it;
    @(posedge clk);
    #1;
    flag_overflow = ovf;
    flag_igual    = eq;
    it.name = nm;
    it.exp  = e;
    sbq.push_back(it);
  endtask

  // FETCH cycle of a new instruction; IR fields are presented from here on
  task automatic fetch(input string nm, input logic [5:0] op, input logic [5:0] fn);
    sb_item_t it;
    @(posedge clk);
    #1;
    opcode        = op;
    funct         = fn;
    flag_overflow = 1'b0;
    flag_igual    = 1'b0;
    it.name = {nm, "_fetch"};
    it.exp  = E_FETCH;
    sbq.push_back(it);
  endtask

  task automatic front(input string nm, input logic [5:0] op, input logic [5:0] fn);
    fetch(nm, op, fn);
    cyc({nm, "_fwait"}, E_FW);
    cyc({nm, "_decode"}, E_DEC);
  endtask

  // Monitor: compare the DUT against the oldest pending expectation
  initial begin
    sb_item_t it;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        it = sbq.pop_front();
        n_checks++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %05h expected %05h at %0t", it.name, act, it.exp, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    opcode        = 6'h00;
    funct         = 6'h00;
    flag_overflow = 1'b0;
    flag_igual    = 1'b0;

    // Reset held for three edges, all outputs quiet
    for (int i = 0; i < 3; i++) cyc("reset", E_ZERO);
    reset = 1'b1;

    // add: 5 cycles, no overflow
    front("add", 6'h00, 6'h20);
    cyc("add_exec", E_XADD);
    cyc("add_wb", E_WBR);

    // sub: ALUControl 010
    front("sub", 6'h00, 6'h22);
    cyc("sub_exec", E_XSUB);
    cyc("sub_wb", E_WBR);

    // and: overflow flag must not trap a logical op
    front("and", 6'h00, 6'h24);
    cyc("and_exec", E_XAND, 1'b1);
    cyc("and_wb", E_WBR);

    // lw: 7 cycles
    front("lw", 6'h23, 6'h10);
    cyc("lw_addr", E_ADDR);
    cyc("lw_memrd", E_MRD);
    cyc("lw_mdrw", E_MWAIT);
    cyc("lw_wb", E_WBM);

    // sw: 5 cycles
    front("sw", 6'h2B, 6'h04);
    cyc("sw_addr", E_ADDR);
    cyc("sw_memwr", E_MWR);

    // Branches, both polarities and both flag values
    front("beq_t", 6'h04, 6'h01);
    cyc("beq_t_br", E_BR_T, 1'b0, 1'b1);
    front("beq_n", 6'h04, 6'h01);
    cyc("beq_n_br", E_BR_N, 1'b0, 1'b0);
    front("bne_t", 6'h05, 6'h01);
    cyc("bne_t_br", E_BR_T, 1'b0, 1'b0);
    front("bne_n", 6'h05, 6'h01);
    cyc("bne_n_br", E_BR_N, 1'b0, 1'b1);

    // j: 4 cycles
    front("j", 6'h02, 6'h00);
    cyc("j_jump", E_JUMP);

    // addi without and with overflow
    front("addi", 6'h08, 6'h05);
    cyc("addi_exec", E_XI);
    cyc("addi_wb", E_WBI);
    front("addi_ov", 6'h08, 6'h05);
    cyc("addi_ov_exec", E_XI, 1'b1);
    cyc("addi_ov_trap", E_TRAP);

    // add with overflow
    front("add_ov", 6'h00, 6'h20);
    cyc("add_ov_exec", E_XADD, 1'b1);
    cyc("add_ov_trap", E_TRAP);

    // Illegal opcode and unlisted R-type funct
    front("ill_op", 6'h3F, 6'h00);
    cyc("ill_op_trap", E_TRAP);
    front("ill_fn", 6'h00, 6'h25);
    cyc("ill_fn_trap", E_TRAP);

    // Reset during ADDR of a store: MEM_WR must never appear
    front("sw_rst", 6'h2B, 6'h08);
    cyc("sw_rst_addr", E_ADDR);
    reset = 1'b0;
    cyc("sw_rst_rst", E_ZERO);
    reset = 1'b1;
    front("post_rst", 6'h02, 6'h00);
    cyc("post_rst_jump", E_JUMP);

    @(negedge clk);
    #1;
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
